// File: rtl/d2d_channel_demux_if.sv
// Link-side flit input and per-channel FIFO outputs of the die-to-die channel demux.
// slave is the demux side; master is the link/consumer side.
interface d2d_channel_demux_if #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 34
);
    localparam int CW = $clog2(CHANNELS);

    logic                                 in_valid;
    logic                                 in_ready;
    logic [FLIT_WIDTH-1:0]                in_data;
    logic [CW-1:0]                        in_channel;
    logic [CHANNELS-1:0]                  out_valid;
    logic [CHANNELS-1:0]                  out_ready;
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_data;
    logic                                 locked;
    logic                                 err;

    modport master (
        output in_valid, in_data, in_channel, out_ready,
        input  in_ready, out_valid, out_data, locked, err
    );

    modport slave (
        input  in_valid, in_data, in_channel, out_ready,
        output in_ready, out_valid, out_data, locked, err
    );
endinterface

// File: rtl/d2d_channel_demux.sv
// Receive-side wormhole demux: steers each packet from the serialized link stream
// into one of CHANNELS small FIFOs, locked to the head's channel until the tail.
module d2d_channel_demux #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    d2d_channel_demux_if.slave bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       lock_ch, lock_n, target;
    logic                head, tail, bad_ch, drop, accept, err_set;
    logic [CHANNELS-1:0] full, push, pop;

    always_comb begin
        head    = bus.in_data[FLIT_WIDTH-1];
        tail    = bus.in_data[FLIT_WIDTH-2];
        bad_ch  = head && (int'(bus.in_channel) >= CHANNELS);
        target  = (state == IDLE || head) ? bus.in_channel : lock_ch;
        // Dropped flits never touch a FIFO, so they are always consumable.
        drop    = bad_ch || (!head && state == IDLE);
        bus.in_ready = !rst && (drop || !full[target]);
        accept  = bus.in_valid && bus.in_ready;
        push    = '0;
        if (accept && !drop)
            push[target] = 1'b1;

        state_n = state;
        lock_n  = lock_ch;
        err_set = 1'b0;
        if (accept) begin
            if (bad_ch) begin
                err_set = 1'b1;
                state_n = IDLE;
            end else if (head) begin
                if (state == BUSY)
                    err_set = 1'b1;
                lock_n  = bus.in_channel;
                state_n = tail ? IDLE : BUSY;
            end else if (state == IDLE) begin
                err_set = 1'b1;
            end else if (tail) begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
            bus.err <= 1'b0;
        end else begin
            state   <= state_n;
            lock_ch <= lock_n;
            if (err_set)
                bus.err <= 1'b1;
        end
    end

    assign bus.locked = (state == BUSY);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [FLIT_WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]         rptr, wptr;
        logic [AW:0]           count;

        assign full[c]          = (count == (AW+1)'(DEPTH));
        assign bus.out_valid[c] = (count != '0);
        assign pop[c]           = bus.out_valid[c] && bus.out_ready[c];
        assign bus.out_data[c]  = mem[rptr];

        always_ff @(posedge clk) begin
            if (push[c])
                mem[wptr] <= bus.in_data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (push[c])
                    wptr <= wptr + AW'(1);
                if (pop[c])
                    rptr <= rptr + AW'(1);
                case ({push[c], pop[c]})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: doc/d2d_channel_demux.md
# d2d_channel_demux

Receive-side counterpart of the die-to-die channel arbiter. It accepts the single serialized flit stream arriving over the chiplet link and steers each wormhole packet to one of CHANNELS output channels, with a small FIFO per channel. A head flit selects the channel, and the demux stays locked to that channel until the tail flit. Backpressure runs toward the link through a valid/ready handshake.

## Interface
- CHANNELS, default 2: number of output channels; legal range 2..16.
- FLIT_WIDTH, default 34: flit width; bit FLIT_WIDTH-1 = head, bit FLIT_WIDTH-2 = tail.
- DEPTH, default 4: entries per channel FIFO; power of two, at least 2.
- clk  input  1  clock; one clock domain.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  flit present on in_data.
- in_ready  output  1  flit is consumed on a clock edge where in_valid & in_ready.
- in_data  input  FLIT_WIDTH  incoming flit.
- in_channel  input  $clog2(CHANNELS)  destination channel; sampled only on head flits.
- out_valid  output  CHANNELS  per-channel FIFO not empty.
- out_ready  input  CHANNELS  per-channel pop on an edge where out_valid[c] & out_ready[c].
- out_data  output  CHANNELS x FLIT_WIDTH  head-of-FIFO flit for each channel.
- locked  output  1  a packet is open (state BUSY).
- err  output  1  sticky protocol-error flag; cleared only by rst.

## Operation
- State machine with two states: IDLE (no open packet) and BUSY (locked to channel lock_ch).
- Target channel:
  - In IDLE, or on any head flit, target = in_channel.
  - Otherwise target = lock_ch.
- in_ready = !rst & (target FIFO count < DEPTH), except in the drop cases below, where in_ready = 1.
  - in_ready is combinational in in_channel and in_data head bit.
  - There is no same-cycle pass-through: a full FIFO blocks input even if it is popping that cycle.
- Accepted flit transitions:
  - Head and tail set (single-flit packet): write to in_channel; stay or return to IDLE.
  - Head only: write to in_channel; lock_ch <= in_channel; go to BUSY.
  - Body or tail in BUSY: write to lock_ch. A tail returns to IDLE.
- Protocol errors (flit is accepted and err <= 1):
  - Head arriving in BUSY: the flit is written to in_channel and the demux re-locks per the rules above. The abandoned packet is not repaired.
  - Body or tail arriving in IDLE: the flit is dropped and no FIFO is written.
  - Head with in_channel >= CHANNELS: the flit is dropped, state becomes IDLE, and subsequent body flits are dropped as IDLE errors.
- Per-channel FIFOs:
  - Circular buffer with $clog2(DEPTH)-bit read and write pointers; both wrap modulo DEPTH.
  - Occupancy counter is $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
  - A simultaneous push and pop on the same FIFO leaves the count unchanged, and both pointers advance.
  - out_data[c] is the entry at the read pointer; its value is don't-care when out_valid[c] = 0.
- Ordering: flits of one packet leave a channel in arrival order. Channels are independent, and a stalled channel never blocks pops on other channels.
- Reset (asynchronous, any cycle including mid-packet):
  - All pointers and counts go to 0; out_valid = 0; state = IDLE; locked = 0; err = 0; in_ready = 0 while rst is high.
  - A packet open at reset is discarded, and its remaining flits after reset are treated as IDLE errors.

## Timing
- Push-to-output latency is one cycle: a flit accepted at edge k is visible on out_valid/out_data after edge k.
- Throughput: one flit per cycle on input and one pop per cycle on each channel.
- When a FIFO is full, in_ready falls in the same cycle the count reaches DEPTH. It rises in the cycle after the pop edge.
- locked and err are registered and update on the accepting edge.
- First in_ready = 1 is in the first cycle after rst deasserts.

## Test plan
- 3-flit packet (head, body, tail) to channel 1 with out_ready = all 1 -> three flits appear on out_data[1] in order, each one cycle after acceptance; locked is 1 after the head edge and 0 after the tail edge; channel 0 out_valid stays 0.
- DEPTH = 4, channel 0 out_ready = 0, 6-flit packet -> 4 flits accepted, then in_ready = 0. Raise out_ready for one cycle -> in_ready is 1 on the next cycle, and the 5th flit is accepted. All 6 flits are drained in order.
- Channel 0 full and stalled; single-flit packet (head + tail) to channel 1 -> in_ready = 1 and the flit appears on channel 1, showing no head-of-line blocking.
- Body flit while IDLE -> accepted, dropped, and err = 1 stays sticky. Head to channel 1 while BUSY on channel 0 -> err stays 1, lock_ch = 1, and the flit lands on channel 1.
- Sustained push and pop on one channel at count 2 for 2*DEPTH cycles -> count stays 2, pointers wrap, and the data sequence is preserved.
- Assert rst mid-packet with 2 flits queued -> out_valid = 0 and locked = 0 immediately. A post-reset tail flit -> dropped with err = 1.
